// File: rtl/nine_segment_pkg.sv
// Shared types for the nine-segment display path.
package nine_segment_pkg;

  localparam int unsigned SEG_W = 9;

  typedef logic [SEG_W-1:0] seg_t;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } arb_state_t;

endpackage

// File: rtl/nine_segment_prescaler.sv
// Free-running display-tick generator: one-cycle scan_en pulse every PRESCALE clocks.
module nine_segment_prescaler #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic scan_en
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  // Count 0..PRESCALE-1 and pulse scan_en the cycle after the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      scan_en <= 1'b0;
    end else begin
      scan_en <= (cnt_q == CNT_MAX);
      cnt_q   <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/nine_segment_arbiter.sv
// Round-robin sharing of one 9-segment display between NUM_REQ requesters.
module nine_segment_arbiter
  import nine_segment_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned PRESCALE      = 1000,
  parameter int unsigned HOLD_TICKS    = 250,
  parameter seg_t        BLANK_PATTERN = 9'h000
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [NUM_REQ-1:0]                                req_valid,
  input  logic [SEG_W*NUM_REQ-1:0]                          req_pattern,
  output logic [NUM_REQ-1:0]                                req_ready,
  output seg_t                                              segments,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                              busy,
  output logic                                              scan_en
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SW = GW + 1;
  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [GW-1:0] LAST_IDX  = GW'(NUM_REQ - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS - 1);

  arb_state_t    state_q;
  logic [GW-1:0] last_grant_q;
  logic [HW-1:0] hold_cnt_q;

  logic [GW-1:0]          start_idx;
  logic [2*NUM_REQ-1:0]   valid_dbl;
  logic [NUM_REQ-1:0]     valid_rot;
  logic [SW-1:0]          win_sum;
  logic                   win_found;
  logic [GW-1:0]          win_idx;
  seg_t                   win_pat;

  nine_segment_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .scan_en (scan_en)
  );

  // Rotate-priority search: first valid index at or after last_grant+1, with wrap.
  always_comb begin
    start_idx = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + 1'b1;
    // Doubling the vector makes the rotate a plain right shift.
    valid_dbl = {req_valid, req_valid} >> start_idx;
    valid_rot = valid_dbl[NUM_REQ-1:0];
    win_found = 1'b0;
    win_idx   = '0;
    win_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && valid_rot[i]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, start_idx} + SW'(i);
        if (win_sum >= SW'(NUM_REQ)) begin
          win_sum = win_sum - SW'(NUM_REQ);
        end
        win_idx = win_sum[GW-1:0];
      end
    end
  end

  // Winner's pattern mux and one-hot ready, only offered while idle and out of reset.
  always_comb begin
    win_pat   = BLANK_PATTERN;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == GW'(i)) begin
        win_pat = req_pattern[i*SEG_W +: SEG_W];
      end
      req_ready[i] = !rst && (state_q == IDLE) && win_found && (win_idx == GW'(i));
    end
  end

  // Grant / show / blank sequencing with registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      segments     <= BLANK_PATTERN;
      grant_id     <= '0;
      last_grant_q <= LAST_IDX;
      busy         <= 1'b0;
      hold_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A winner always sees ready, so a found winner is a completed handshake.
          if (win_found) begin
            segments     <= win_pat;
            grant_id     <= win_idx;
            last_grant_q <= win_idx;
            hold_cnt_q   <= HOLD_INIT;
            busy         <= 1'b1;
            state_q      <= SHOW;
          end
        end
        SHOW: begin
          if (scan_en) begin
            if (hold_cnt_q == '0) begin
              segments <= BLANK_PATTERN;
              state_q  <= BLANK;
            end else begin
              hold_cnt_q <= hold_cnt_q - 1'b1;
            end
          end
        end
        BLANK: begin
          if (scan_en) begin
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nine_segment_arbiter.sv
// Self-checking bench for nine_segment_arbiter (NUM_REQ=3, PRESCALE=4, HOLD_TICKS=2).
module tb_nine_segment_arbiter;
  import nine_segment_pkg::*;

  localparam int NR = 3;
  localparam int PS = 4;
  localparam int HT = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [9*NR-1:0]  req_pattern;
  logic [NR-1:0]    req_ready;
  seg_t             segments;
  logic [1:0]       grant_id;
  logic             busy;
  logic             scan_en;
  seg_t             pat [NR];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) req_pattern[i*9 +: 9] = pat[i];
  end

  nine_segment_arbiter #(
    .NUM_REQ       (NR),
    .PRESCALE      (PS),
    .HOLD_TICKS    (HT),
    .BLANK_PATTERN (9'h000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_pattern (req_pattern),
    .req_ready   (req_ready),
    .segments    (segments),
    .grant_id    (grant_id),
    .busy        (busy),
    .scan_en     (scan_en)
  );

  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge k counted from reset release; a display tick is observed at
  // edge m when m > PS and (m-1) is a multiple of PS. Dwell ends are computed up front.
  int   k;
  int   m_mode;  // 0 idle, 1 show, 2 blank
  int   m_show_end;
  int   m_blank_end;
  int   m_last;
  int   m_gid;
  seg_t m_seg;
  bit   m_busy;
  int   acc_q[$];

  function automatic int m_winner();
    for (int i = 0; i < NR; i++) begin
      int idx;
      idx = (m_last + 1 + i) % NR;
      if (((req_valid >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  function automatic int next_tick_edge(input int n);
    int m;
    m = n + 1;
    while (!(m >= PS + 1 && (m - 1) % PS == 0)) m++;
    return m;
  endfunction

  task automatic model_reset();
    k = 0; m_mode = 0; m_last = NR - 1; m_gid = 0; m_seg = '0; m_busy = 1'b0;
  endtask

  // One clock: check ready before the edge, advance model, check registered outputs after.
  task automatic step();
    int            w;
    logic [NR-1:0] exp_rdy;
    bit            acc;
    w = m_winner();
    exp_rdy = '0;
    if (m_mode == 0 && w >= 0) exp_rdy = NR'(1) << w;
    #1 check("req_ready", req_ready, exp_rdy);
    @(posedge clk);
    k++;
    acc = 1'b0;
    case (m_mode)
      0: if (w >= 0) begin
        m_seg = pat[w]; m_gid = w; m_last = w; m_busy = 1'b1; m_mode = 1; acc = 1'b1;
        m_show_end  = next_tick_edge(k) + PS * (HT - 1);
        m_blank_end = m_show_end + PS;
      end
      1: if (k == m_show_end) begin m_seg = '0; m_mode = 2; end
      2: if (k == m_blank_end) begin m_mode = 0; m_busy = 1'b0; end
      default: ;
    endcase
    #1;
    check("segments", segments, m_seg);
    check("busy", busy, m_busy);
    check("grant_id", grant_id, m_gid);
    check("scan_en", scan_en, (k >= PS && k % PS == 0));
    if (acc) acc_q.push_back(int'(grant_id));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_segments", segments, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin step(); n++; end
    check("wait_idle", busy, 0);
  endtask

  task automatic wait_accepts(input int target, input int budget);
    int n;
    n = 0;
    while (acc_q.size() < target && n < budget) begin step(); n++; end
    check("wait_accept", acc_q.size(), target);
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] exp_ready;
    logic [1:0]    exp_gid;
    seg_t          exp_seg;
  } vec_t;

  vec_t vecs[6];
  int   gaps[$];
  int   zero_run;
  int   n;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; req_valid = '0;
    for (int i = 0; i < NR; i++) pat[i] = '0;
    @(negedge clk);
    do_reset();

    // Single requester: accept, two-tick show, one blank tick.
    pat[0] = 9'h0AA; req_valid = 3'b001;
    #1 check("t2_ready", req_ready, 3'b001);
    step();
    check("t2_seg", segments, 9'h0AA);
    check("t2_gid", grant_id, 0);
    req_valid = '0;
    n = 0;
    while (segments !== 9'h000 && n < 40) begin step(); n++; end
    check("t2_show_cycles", n, 8);
    n = 0;
    while (busy === 1'b1 && n < 40) begin step(); n++; end
    check("t2_blank_cycles", n, 4);

    // Table of grants in sequence from reset; rotation follows each previous winner.
    vecs[0] = '{3'b001, 3'b001, 2'd0, 9'h111};
    vecs[1] = '{3'b110, 3'b010, 2'd1, 9'h122};
    vecs[2] = '{3'b011, 3'b001, 2'd0, 9'h111};
    vecs[3] = '{3'b100, 3'b100, 2'd2, 9'h144};
    vecs[4] = '{3'b111, 3'b001, 2'd0, 9'h111};
    vecs[5] = '{3'b101, 3'b100, 2'd2, 9'h144};
    do_reset();
    pat[0] = 9'h111; pat[1] = 9'h122; pat[2] = 9'h144;
    for (int v = 0; v < 6; v++) begin
      req_valid = vecs[v].valid;
      #1 check("tbl_ready", req_ready, vecs[v].exp_ready);
      step();
      check("tbl_gid", grant_id, vecs[v].exp_gid);
      check("tbl_seg", segments, vecs[v].exp_seg);
      req_valid = '0;
      run_until_idle(50);
    end

    // All valid continuously: order 0,1,2,0 with a blank gap between patterns.
    do_reset();
    pat[0] = 9'h001; pat[1] = 9'h002; pat[2] = 9'h004;
    req_valid = 3'b111;
    acc_q.delete(); gaps.delete(); zero_run = 0; n = 0;
    while (acc_q.size() < 4 && n < 200) begin
      step(); n++;
      if (acc_q.size() >= 1 && segments == 9'h000) zero_run++;
      else if (zero_run > 0) begin gaps.push_back(zero_run); zero_run = 0; end
    end
    check("rr_count", acc_q.size(), 4);
    if (acc_q.size() == 4) begin
      check("rr_0", acc_q[0], 0);
      check("rr_1", acc_q[1], 1);
      check("rr_2", acc_q[2], 2);
      check("rr_3", acc_q[3], 0);
    end
    // One blank tick plus the IDLE accept cycle.
    check("rr_gaps", gaps.size(), 3);
    if (gaps.size() >= 2) begin
      check("rr_gap0", gaps[0], PS + 1);
      check("rr_gap1", gaps[1], PS + 1);
    end
    req_valid = '0;
    run_until_idle(50);

    // req2 alone, then req0+req2: rotation gives 0 before 2.
    do_reset();
    acc_q.delete();
    pat[2] = 9'h155; req_valid = 3'b100;
    wait_accepts(1, 10);
    pat[0] = 9'h033; req_valid = 3'b101;
    wait_accepts(3, 100);
    if (acc_q.size() == 3) begin
      check("rot_first", acc_q[0], 2);
      check("rot_second", acc_q[1], 0);
      check("rot_third", acc_q[2], 2);
    end
    req_valid = '0;
    run_until_idle(50);

    // req1 asks only during SHOW and withdraws: no grant to it.
    do_reset();
    acc_q.delete();
    pat[0] = 9'h0F0; req_valid = 3'b001;
    wait_accepts(1, 10);
    pat[1] = 9'h10F; req_valid = 3'b010;
    repeat (3) step();
    req_valid = '0;
    run_until_idle(50);
    repeat (10) step();
    check("wd_accepts", acc_q.size(), 1);
    check("wd_busy", busy, 0);

    // Reset in the middle of SHOW discards the pattern.
    do_reset();
    pat[0] = 9'h1FF; req_valid = 3'b001;
    step();
    check("mid_seg", segments, 9'h1FF);
    repeat (3) step();
    do_reset();
    pat[1] = 9'h1C3; req_valid = 3'b010;
    #1 check("mid_ready", req_ready, 3'b010);
    step();
    check("mid_gid", grant_id, 1);
    check("mid_seg2", segments, 9'h1C3);
    req_valid = '0;
    run_until_idle(50);

    // Random valid traffic against the model; patterns only change while not offered.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          if (req_valid[i]) req_valid[i] = 1'b0;
          else begin
            pat[i] = 9'($urandom_range(0, 511));
            req_valid[i] = 1'b1;
          end
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
